// File: rtl/fifo_rdarb_pkg.sv
// Shared types and constants for the FIFO read arbiter.
// Holds the FSM state type, head-type codes and the select-width helper.
package fifo_rdarb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  localparam logic [2:0] HEAD_BODY   = 3'b000;
  localparam logic [2:0] HEAD_FIRST  = 3'b100;
  localparam logic [2:0] HEAD_SINGLE = 3'b111;
  localparam logic [2:0] TAIL_CODE_DEF = 3'b110;

  // A single channel still needs a one-bit select.
  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_read_arbiter_if.sv
// Handshake bundle between the input FIFOs / crossbar port and the read arbiter.
// master = arbiter side, slave = FIFO/crossbar side.
interface fifo_read_arbiter_if
  import fifo_rdarb_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int HEAD_W = 3,
  parameter int SEL_W  = sel_w(NUM_CH)
);
  logic [NUM_CH-1:0]        fifo_empty;
  logic [NUM_CH*HEAD_W-1:0] head_bus;
  logic                     busy;
  logic                     req;
  logic [NUM_CH-1:0]        fifo_read;
  logic [SEL_W-1:0]         fifo_sel;
  logic                     pkt_active;
  logic                     grant_valid;

  modport master (
    input  fifo_empty, head_bus, busy,
    output req, fifo_read, fifo_sel, pkt_active, grant_valid
  );

  modport slave (
    output fifo_empty, head_bus, busy,
    input  req, fifo_read, fifo_sel, pkt_active, grant_valid
  );
endinterface

// File: rtl/prio_pick.sv
// Combinational lowest-index picker: isolates the lowest set request bit
// and encodes its index.
module prio_pick #(
  parameter int NUM_CH = 2,
  parameter int SEL_W  = 1
) (
  input  logic [NUM_CH-1:0] i_req,
  output logic [NUM_CH-1:0] o_onehot,
  output logic [SEL_W-1:0]  o_idx
);

  // Two's-complement trick keeps only the lowest set bit.
  assign o_onehot = i_req & (~i_req + NUM_CH'(1));

  always_comb begin
    o_idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_read_arbiter.sv
// Wormhole-locking fixed-priority read arbiter draining NUM_CH FIFOs into one link.
// Optional starvation aging is enabled by defining FIFO_RDARB_AGING_EN.
module fifo_read_arbiter
  import fifo_rdarb_pkg::*;
#(
  parameter int              NUM_CH     = 2,
  parameter int              HEAD_W     = 3,
  parameter logic [HEAD_W-1:0] TAIL_CODE = HEAD_W'(TAIL_CODE_DEF),
  parameter int              STARVE_MAX = 15,
  parameter int              SEL_W      = sel_w(NUM_CH)
) (
  input logic                  clk,
  input logic                  rst,
  fifo_read_arbiter_if.master  bus
);

  logic [NUM_CH-1:0] w_nonempty;
  logic [NUM_CH-1:0] w_ne_oh;
  logic [NUM_CH-1:0] w_win_oh;
  logic [NUM_CH-1:0] w_read;
  logic [SEL_W-1:0]  w_ne_idx;
  logic [SEL_W-1:0]  w_win_idx;
  logic [HEAD_W-1:0] w_head;
  logic              w_win_any;
  logic              w_pop;
  logic              w_tail;

  state_e            r_state;
  logic [SEL_W-1:0]  r_sel;
  logic              r_pkt_active;
  logic              r_grant_valid;

  assign w_nonempty = ~bus.fifo_empty;

  prio_pick #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_pick_ne (
    .i_req    (w_nonempty),
    .o_onehot (w_ne_oh),
    .o_idx    (w_ne_idx)
  );

  // An aging threshold below one cycle has no meaning; nothing is built for it.
  if (STARVE_MAX < 1) begin : g_starve_max_unsupported
  end

`ifdef FIFO_RDARB_AGING_EN
  localparam int AGE_W = $clog2(STARVE_MAX + 1);

  logic [AGE_W-1:0]  r_age [NUM_CH];
  logic [NUM_CH-1:0] w_starved;
  logic [NUM_CH-1:0] w_served;
  logic [NUM_CH-1:0] w_st_oh;
  logic [SEL_W-1:0]  w_st_idx;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_age_flags
    assign w_starved[gi] = w_nonempty[gi] && (r_age[gi] == AGE_W'(STARVE_MAX));
    // Served means granted this cycle (IDLE) or currently holding the lock.
    assign w_served[gi]  = (r_state == IDLE) ? w_win_oh[gi]
                                             : (r_sel == SEL_W'(gi));
  end

  prio_pick #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_pick_starved (
    .i_req    (w_starved),
    .o_onehot (w_st_oh),
    .o_idx    (w_st_idx)
  );

  assign w_win_oh  = (|w_st_oh) ? w_st_oh  : w_ne_oh;
  assign w_win_idx = (|w_st_oh) ? w_st_idx : w_ne_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!w_nonempty[i] || w_served[i]) begin
          r_age[i] <= '0;
        end else if (r_age[i] != AGE_W'(STARVE_MAX)) begin
          r_age[i] <= r_age[i] + AGE_W'(1);
        end
      end
    end
  end
`else
  assign w_win_oh  = w_ne_oh;
  assign w_win_idx = w_ne_idx;
`endif

  assign w_win_any = |w_win_oh;
  assign w_head    = bus.head_bus[r_sel*HEAD_W +: HEAD_W];
  assign w_tail    = (w_head == TAIL_CODE);
  assign w_pop     = (r_state == LOCKED) && !bus.busy && !bus.fifo_empty[r_sel];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_read
    assign w_read[gi] = w_pop && (r_sel == SEL_W'(gi));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_sel         <= '0;
      r_pkt_active  <= 1'b0;
      r_grant_valid <= 1'b0;
    end else begin
      r_grant_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_win_any) begin
            r_state       <= LOCKED;
            r_sel         <= w_win_idx;
            r_pkt_active  <= 1'b1;
            r_grant_valid <= 1'b1;
          end
        end
        LOCKED: begin
          // Lock is released only by an actual tail pop, never by emptiness.
          if (w_pop && w_tail) begin
            r_state      <= IDLE;
            r_pkt_active <= 1'b0;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_pkt_active <= 1'b0;
        end
      endcase
    end
  end

  assign bus.fifo_read   = w_read;
  assign bus.fifo_sel    = r_sel;
  assign bus.pkt_active  = r_pkt_active;
  assign bus.grant_valid = r_grant_valid;
  assign bus.req         = r_pkt_active | ~&bus.fifo_empty;

endmodule
